// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its sequencer.
//   opcode_t / operand_t / address_t : instruction payload and slot index
//   ctrl_state_t                      : sequencer control state
//   SEQ_DEPTH                         : default sequencer queue depth
package instr_register_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned OPND_W    = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned SEQ_DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [OPND_W-1:0] operand_t;
  typedef logic [ADDR_W-1:0]        address_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} ctrl_state_t;

  // Opcodes that would trap on a zero divisor.
  function automatic logic is_div_op(input opcode_t op);
    return (op == DIV) || (op == MOD);
  endfunction

endpackage

// File: rtl/instr_reg_sequencer_rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   rq_valid : request lines, [0] = producer 0
//   advance  : a granted transfer was accepted this cycle
//   grant    : one-hot grant (combinational), 0 when nobody requests
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] rq_valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  // Contention goes to whoever was not served last.
  always_comb begin
    grant = rq_valid;
    if (rq_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Reset to 1 so producer 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (advance && (|grant)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/instr_reg_sequencer.sv
// Controller for the instruction register: arbitrates two producers onto the
// write port, tracks the circular queue pointers and hands entries in order
// to one consumer. Holds no instruction data.
//   start/stop/flush           : control requests
//   rq_valid/rq_ready/rq_*     : producer handshake and payloads
//   load_en/write_pointer/...  : register write port (combinational)
//   read_pointer/iw_valid/ready: consumer side
//   count/state/err_div0       : status
module instr_reg_sequencer
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = SEQ_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              flush,
  input  logic [1:0]        rq_valid,
  output logic [1:0]        rq_ready,
  input  opcode_t  [1:0]    rq_opcode,
  input  operand_t [1:0]    rq_operand_a,
  input  operand_t [1:0]    rq_operand_b,
  output logic              load_en,
  output address_t          write_pointer,
  output opcode_t           opcode,
  output operand_t          operand_a,
  output operand_t          operand_b,
  output address_t          read_pointer,
  output logic              iw_valid,
  input  logic              iw_ready,
  output logic [CNT_W-1:0]  count,
  output ctrl_state_t       state,
  output logic              err_div0
);

  ctrl_state_t      state_q, state_d;
  address_t         wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       grant;
  logic             accept, rd_fire, sel;

  // Full blocks writes regardless of a same-cycle read.
  assign accept   = (state_q == RUN) && !flush && (count_q != CNT_W'(DEPTH));
  assign rq_ready = accept ? grant : 2'b00;
  assign load_en  = |rq_ready;
  assign iw_valid = (state_q != IDLE) && (count_q != '0) && !flush;
  assign rd_fire  = iw_valid && iw_ready;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .rq_valid (rq_valid),
    .advance  (accept),
    .grant    (grant)
  );

  // Payload mux defaults to producer 0 when nothing is granted.
  assign sel           = grant[1];
  assign opcode        = rq_opcode[sel];
  assign operand_a     = rq_operand_a[sel];
  assign operand_b     = rq_operand_b[sel];
  assign write_pointer = wr_ptr;
  assign read_pointer  = rd_ptr;
  assign count         = count_q;
  assign state         = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush > stop > start.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start && !stop) state_d = RUN;
        RUN:     if (stop) state_d = DRAIN;
        DRAIN:   if (count_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy; wrap at DEPTH-1 keeps upper bits zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (load_en) begin
        wr_ptr <= (wr_ptr == address_t'(DEPTH-1)) ? '0 : wr_ptr + address_t'(1);
      end
      if (rd_fire) begin
        rd_ptr <= (rd_ptr == address_t'(DEPTH-1)) ? '0 : rd_ptr + address_t'(1);
      end
      case ({load_en, rd_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Divide-by-zero flag for the entry written this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_div0 <= 1'b0;
    end else begin
      err_div0 <= load_en && is_div_op(opcode) && (operand_b == '0);
    end
  end

endmodule

// File: tb/tb_instr_reg_sequencer.sv
module tb_instr_reg_sequencer;
  import instr_register_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0, stop = 1'b0, flush = 1'b0;
  logic [1:0]      rq_valid = 2'b00;
  logic [1:0]      rq_ready;
  opcode_t  [1:0]  rq_opcode;
  operand_t [1:0]  rq_operand_a;
  operand_t [1:0]  rq_operand_b;
  logic            load_en;
  address_t        write_pointer;
  opcode_t         opcode;
  operand_t        operand_a, operand_b;
  address_t        read_pointer;
  logic            iw_valid;
  logic            iw_ready = 1'b0;
  logic [5:0]      count;
  ctrl_state_t     state;
  logic            err_div0;

  int tests = 0;
  int fails = 0;

  instr_reg_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .flush(flush),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_opcode(rq_opcode),
    .rq_operand_a(rq_operand_a), .rq_operand_b(rq_operand_b),
    .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .read_pointer(read_pointer),
    .iw_valid(iw_valid), .iw_ready(iw_ready), .count(count), .state(state),
    .err_div0(err_div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, sp, fl;
    logic [1:0]  v;
    logic        ir;
    logic [1:0]  e_rdy;
    logic        e_ld;
    logic [4:0]  e_wp;
    logic        e_iv;
    logic [4:0]  e_rp;
    logic [5:0]  e_cnt;
    ctrl_state_t e_st;
    opcode_t     e_op;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input logic st, input logic sp, input logic fl,
                              input logic [1:0] v, input logic ir,
                              input logic [1:0] rdy, input logic ld, input logic [4:0] wp,
                              input logic iv, input logic [4:0] rp, input logic [5:0] cnt,
                              input ctrl_state_t s, input opcode_t op);
    vec_t r;
    r.st = st; r.sp = sp; r.fl = fl; r.v = v; r.ir = ir;
    r.e_rdy = rdy; r.e_ld = ld; r.e_wp = wp; r.e_iv = iv; r.e_rp = rp;
    r.e_cnt = cnt; r.e_st = s; r.e_op = op;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input opcode_t op, input operand_t a, input operand_t b);
    rq_opcode[0] = op; rq_operand_a[0] = a; rq_operand_b[0] = b;
  endtask

  // Reset asynchronously, check outputs drop without a clock, release away from an edge.
  task automatic do_reset();
    start = 1'b0; stop = 1'b0; flush = 1'b0; rq_valid = 2'b00; iw_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_rq_ready", 32'(rq_ready), 32'd0);
    chk("rst_load_en",  32'(load_en),  32'd0);
    chk("rst_iw_valid", 32'(iw_valid), 32'd0);
    chk("rst_err_div0", 32'(err_div0), 32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_state",    32'(state),    32'(IDLE));
    chk("rst_wp",       32'(write_pointer), 32'd0);
    chk("rst_rp",       32'(read_pointer),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
  endtask

  int reads;
  bit done;

  initial begin
    set_p0(ADD, 32'sd5, 32'sd3);
    rq_opcode[1] = SUB; rq_operand_a[1] = 32'sd7; rq_operand_b[1] = 32'sd2;

    // Start, then both producers contend for four cycles; consumer stalled.
    tbl[0] = mk(1'b1,1'b0,1'b0, 2'b00,1'b0, 2'b00,1'b0,5'd0, 1'b0,5'd0,6'd0, IDLE, ADD);
    tbl[1] = mk(1'b0,1'b0,1'b0, 2'b11,1'b0, 2'b01,1'b1,5'd0, 1'b0,5'd0,6'd0, RUN,  ADD);
    tbl[2] = mk(1'b0,1'b0,1'b0, 2'b11,1'b0, 2'b10,1'b1,5'd1, 1'b1,5'd0,6'd1, RUN,  SUB);
    tbl[3] = mk(1'b0,1'b0,1'b0, 2'b11,1'b0, 2'b01,1'b1,5'd2, 1'b1,5'd0,6'd2, RUN,  ADD);
    tbl[4] = mk(1'b0,1'b0,1'b0, 2'b11,1'b0, 2'b10,1'b1,5'd3, 1'b1,5'd0,6'd3, RUN,  SUB);
    tbl[5] = mk(1'b0,1'b0,1'b0, 2'b00,1'b0, 2'b00,1'b0,5'd4, 1'b1,5'd0,6'd4, RUN,  ADD);

    do_reset();

    for (int i = 0; i < 6; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; flush = tbl[i].fl;
      rq_valid = tbl[i].v; iw_ready = tbl[i].ir;
      #1;
      chk($sformatf("v%0d_rq_ready", i), 32'(rq_ready),      32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_load_en", i),  32'(load_en),       32'(tbl[i].e_ld));
      chk($sformatf("v%0d_wp", i),       32'(write_pointer), 32'(tbl[i].e_wp));
      chk($sformatf("v%0d_iw_valid", i), 32'(iw_valid),      32'(tbl[i].e_iv));
      chk($sformatf("v%0d_rp", i),       32'(read_pointer),  32'(tbl[i].e_rp));
      chk($sformatf("v%0d_count", i),    32'(count),         32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_state", i),    32'(state),         32'(tbl[i].e_st));
      chk($sformatf("v%0d_opcode", i),   32'(opcode),        32'(tbl[i].e_op));
      chk($sformatf("v%0d_err", i),      32'(err_div0),      32'd0);
      cyc();
    end

    // Fill to full with the consumer stalled.
    rq_valid = 2'b01; iw_ready = 1'b0;
    for (int i = 0; i < 28; i++) begin
      #1;
      chk($sformatf("fill%0d_rq_ready", i), 32'(rq_ready), 32'b01);
      cyc();
    end
    #1;
    chk("full_rq_ready", 32'(rq_ready), 32'd0);
    chk("full_load_en",  32'(load_en),  32'd0);
    chk("full_count",    32'(count),    32'd32);
    chk("full_wp_wrap",  32'(write_pointer), 32'd0);
    iw_ready = 1'b1;
    #1;
    chk("full_rd_iw_valid", 32'(iw_valid), 32'd1);
    chk("full_rd_rq_ready", 32'(rq_ready), 32'd0);
    cyc();
    iw_ready = 1'b0;
    #1;
    chk("after_rd_count",    32'(count),         32'd31);
    chk("after_rd_rp",       32'(read_pointer),  32'd1);
    chk("after_rd_rq_ready", 32'(rq_ready),      32'b01);
    chk("after_rd_wp",       32'(write_pointer), 32'd0);
    cyc();
    #1;
    chk("refull_count", 32'(count),         32'd32);
    chk("refull_wp",    32'(write_pointer), 32'd1);

    // Reset mid-operation with a full queue.
    do_reset();

    // Simultaneous write and read at count 5.
    start = 1'b1; cyc(); start = 1'b0;
    rq_valid = 2'b01;
    for (int i = 0; i < 5; i++) cyc();
    iw_ready = 1'b1;
    #1;
    chk("wr_rd_pre_count", 32'(count),         32'd5);
    chk("wr_rd_load_en",   32'(load_en),       32'd1);
    chk("wr_rd_iw_valid",  32'(iw_valid),      32'd1);
    chk("wr_rd_pre_wp",    32'(write_pointer), 32'd5);
    chk("wr_rd_pre_rp",    32'(read_pointer),  32'd0);
    cyc();
    iw_ready = 1'b0;
    #1;
    chk("wr_rd_count", 32'(count),         32'd5);
    chk("wr_rd_wp",    32'(write_pointer), 32'd6);
    chk("wr_rd_rp",    32'(read_pointer),  32'd1);

    // Flush at count 7, with a producer and consumer both active.
    cyc(); cyc();
    flush = 1'b1; iw_ready = 1'b1;
    #1;
    chk("flush_pre_count", 32'(count),    32'd7);
    chk("flush_load_en",   32'(load_en),  32'd0);
    chk("flush_rq_ready",  32'(rq_ready), 32'd0);
    chk("flush_iw_valid",  32'(iw_valid), 32'd0);
    cyc();
    flush = 1'b0; rq_valid = 2'b00; iw_ready = 1'b0;
    #1;
    chk("post_flush_count",    32'(count),         32'd0);
    chk("post_flush_state",    32'(state),         32'(IDLE));
    chk("post_flush_iw_valid", 32'(iw_valid),      32'd0);
    chk("post_flush_wp",       32'(write_pointer), 32'd0);
    chk("post_flush_rp",       32'(read_pointer),  32'd0);

    // Divide by zero is flagged for exactly one cycle and still written.
    start = 1'b1; cyc(); start = 1'b0;
    set_p0(DIV, 32'sd9, 32'sd0);
    rq_valid = 2'b01;
    #1;
    chk("div0_load_en", 32'(load_en), 32'd1);
    chk("div0_err_pre", 32'(err_div0), 32'd0);
    cyc();
    set_p0(ADD, 32'sd5, 32'sd3);
    #1;
    chk("div0_err",   32'(err_div0), 32'd1);
    chk("div0_count", 32'(count),    32'd1);
    cyc();
    #1;
    chk("div0_err_clear", 32'(err_div0), 32'd0);
    chk("div0_count2",    32'(count),    32'd2);
    cyc();
    rq_valid = 2'b00; stop = 1'b1;
    cyc();
    stop = 1'b0;
    #1;
    chk("drain_state", 32'(state), 32'(DRAIN));
    chk("drain_count", 32'(count), 32'd3);

    // Drain with the consumer ready; producer requests must be refused.
    rq_valid = 2'b01; iw_ready = 1'b1;
    reads = 0; done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      if (state == IDLE) begin
        done = 1'b1;
      end else begin
        chk($sformatf("drain%0d_rq_ready", k), 32'(rq_ready), 32'd0);
        if (iw_valid && iw_ready) reads++;
        cyc();
        #1;
      end
    end
    chk("drain_done",  32'(done),  32'd1);
    chk("drain_reads", 32'(reads), 32'd3);
    chk("drain_idle",  32'(state), 32'(IDLE));
    chk("drain_count_end", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
